// File: rtl/multi_timer_if.sv
// Configuration, flag-clear, status and readback bus of the multi_timer block.
// The CPU side (master) drives configuration and readback select; the timer (slave) reports status.
interface multi_timer_if #(
  parameter int WIDTH = 16,
  parameter int N_CH  = 4
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_we;
  logic [CW-1:0]    cfg_ch;
  logic [WIDTH-1:0] cfg_period;
  logic             cfg_periodic;
  logic             cfg_start;
  logic [N_CH-1:0]  flag_clr;
  logic [CW-1:0]    rd_ch;

  logic [N_CH-1:0]  expire;
  logic [N_CH-1:0]  flag;
  logic [N_CH-1:0]  active;
  logic [WIDTH-1:0] rd_count;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_periodic, cfg_start, flag_clr, rd_ch,
    input  expire, flag, active, rd_count
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_periodic, cfg_start, flag_clr, rd_ch,
    output expire, flag, active, rd_count
  );
endinterface

// File: rtl/multi_timer.sv
// Prescaled tick time base with N_CH independent one-shot/periodic down-count channels.
// All outputs are registered; reset is synchronous and active-low.
module multi_timer #(
  parameter int DIV   = 12500,
  parameter int WIDTH = 16,
  parameter int N_CH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             tick,
  output logic [WIDTH-1:0] out_time,
  multi_timer_if.slave     bus
);
  localparam int PW = $clog2(DIV);

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] out_time_q, out_time_d;

  logic [WIDTH-1:0] cnt_q    [N_CH];
  logic [WIDTH-1:0] cnt_d    [N_CH];
  logic [WIDTH-1:0] reload_q [N_CH];
  logic [WIDTH-1:0] reload_d [N_CH];
  logic [N_CH-1:0]  periodic_q, periodic_d;
  logic [N_CH-1:0]  active_q, active_d;
  logic [N_CH-1:0]  expire_q, expire_d;
  logic [N_CH-1:0]  flag_q, flag_d;
  logic [WIDTH-1:0] rd_count_q, rd_count_d;

  logic [N_CH-1:0]  wr_hit;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    tick_d = 1'b0;
    pre_d  = pre_q;
    if (run) begin
      if (pre_q == PW'(DIV - 1)) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    out_time_d = tick_q ? out_time_q + WIDTH'(1) : out_time_q;
  end

  // A write that would arm with period 0 counts as no write at all, so the tick still applies.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = bus.cfg_we && (int'(bus.cfg_ch) == i) &&
                  (!bus.cfg_start || (bus.cfg_period != '0));
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      reload_d[i] = reload_q[i];
    end
    periodic_d = periodic_q;
    active_d   = active_q;
    expire_d   = '0;
    flag_d     = flag_q & ~bus.flag_clr;

    for (int i = 0; i < N_CH; i++) begin
      if (wr_hit[i]) begin
        // A valid write to this channel masks any same-cycle tick for it.
        if (bus.cfg_start) begin
          cnt_d[i]      = bus.cfg_period;
          reload_d[i]   = bus.cfg_period;
          periodic_d[i] = bus.cfg_periodic;
          active_d[i]   = 1'b1;
        end else begin
          active_d[i] = 1'b0;
        end
      end else if (tick_q && active_q[i]) begin
        if (cnt_q[i] == WIDTH'(1)) begin
          expire_d[i] = 1'b1;
          flag_d[i]   = 1'b1;
          if (periodic_q[i]) begin
            cnt_d[i] = reload_q[i];
          end else begin
            cnt_d[i]    = '0;
            active_d[i] = 1'b0;
          end
        end else if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    rd_count_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(bus.rd_ch) == i) rd_count_d = cnt_q[i];
    end
  end

  // NOTE: counter and reload arrays are cleared on reset too, since a stale count must never resume or read back.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      pre_q      <= '0;
      tick_q     <= 1'b0;
      out_time_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]    <= '0;
        reload_q[i] <= '0;
      end
      periodic_q <= '0;
      active_q   <= '0;
      expire_q   <= '0;
      flag_q     <= '0;
      rd_count_q <= '0;
    end else begin
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      out_time_q <= out_time_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        reload_q[i] <= reload_d[i];
      end
      periodic_q <= periodic_d;
      active_q   <= active_d;
      expire_q   <= expire_d;
      flag_q     <= flag_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign tick         = tick_q;
  assign out_time     = out_time_q;
  assign bus.expire   = expire_q;
  assign bus.flag     = flag_q;
  assign bus.active   = active_q;
  assign bus.rd_count = rd_count_q;
endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: a tick-count/deadline reference model is compared every cycle,
// alongside directed timing checks and a randomized configuration phase.
module tb_multi_timer;
  localparam int DIV   = 4;
  localparam int WIDTH = 8;
  localparam int N_CH  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic             tick;
  logic [WIDTH-1:0] out_time;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multi_timer_if #(.WIDTH(WIDTH), .N_CH(N_CH)) bus ();

  multi_timer #(.DIV(DIV), .WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .tick     (tick),
    .out_time (out_time),
    .bus      (bus)
  );

  // Reference model: ticks are counted absolutely; a running channel is a deadline tick number.
  int              m_runs;
  bit              m_tick;
  int              m_ticks;
  bit [N_CH-1:0]   m_on;
  bit [N_CH-1:0]   m_periodic;
  bit [N_CH-1:0]   m_expire;
  bit [N_CH-1:0]   m_flag;
  int              m_per  [N_CH];
  int              m_dl   [N_CH];
  int              m_held [N_CH];
  int              m_rd;

  function automatic int cnt_of(input int ch);
    if (ch >= N_CH) return 0;
    return m_on[ch] ? (m_dl[ch] - m_ticks) : m_held[ch];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_step();
    int t0;
    if (!rst_n) begin
      m_runs = 0; m_tick = 0; m_ticks = 0; m_rd = 0;
      m_on = '0; m_periodic = '0; m_expire = '0; m_flag = '0;
      for (int i = 0; i < N_CH; i++) begin
        m_per[i] = 0; m_dl[i] = 0; m_held[i] = 0;
      end
    end else begin
      m_rd = cnt_of(int'(bus.rd_ch));
      t0 = m_ticks;
      if (m_tick) m_ticks++;
      m_expire = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (bus.cfg_we && int'(bus.cfg_ch) == i && (!bus.cfg_start || bus.cfg_period != 0)) begin
          if (bus.cfg_start) begin
            m_on[i]       = 1'b1;
            m_per[i]      = int'(bus.cfg_period);
            m_periodic[i] = bus.cfg_periodic;
            m_dl[i]       = m_ticks + m_per[i];
          end else if (m_on[i]) begin
            m_held[i] = m_dl[i] - t0;
            m_on[i]   = 1'b0;
          end
        end else if (m_tick && m_on[i] && m_ticks == m_dl[i]) begin
          m_expire[i] = 1'b1;
          if (m_periodic[i]) m_dl[i] += m_per[i];
          else begin
            m_on[i]   = 1'b0;
            m_held[i] = 0;
          end
        end
      end
      m_flag = (m_flag & ~bus.flag_clr) | m_expire;
      m_tick = run && (((m_runs + 1) % DIV) == 0);
      if (run) m_runs++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("tick",     32'(tick),         32'(m_tick));
    check("out_time", 32'(out_time),     32'(m_ticks % (1 << WIDTH)));
    check("expire",   32'(bus.expire),   32'(m_expire));
    check("flag",     32'(bus.flag),     32'(m_flag));
    check("active",   32'(bus.active),   32'(m_on));
    check("rd_count", 32'(bus.rd_count), 32'(m_rd % (1 << WIDTH)));
  endtask

  task automatic cfg_write(input int ch, input int period, input bit periodic, input bit start);
    bus.cfg_we       = 1'b1;
    bus.cfg_ch       = ch[0];
    bus.cfg_period   = period[WIDTH-1:0];
    bus.cfg_periodic = periodic;
    bus.cfg_start    = start;
    cycle();
    bus.cfg_we = 1'b0;
  endtask

  task automatic wait_tick(output int n, output bit found);
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      cycle(); n++;
      if (tick) found = 1'b1;
    end
  endtask

  task automatic wait_expire(input int ch, output int n, output bit found);
    n = 0; found = 1'b0;
    while (!found && n < 200) begin
      cycle(); n++;
      if (bus.expire[ch]) found = 1'b1;
    end
  endtask

  // Advance until channel 0 is one tick from expiring with that tick pending this cycle.
  task automatic wait_pre_expire0(output bit found);
    int n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      if (m_tick && m_on[0] && cnt_of(0) == 1) found = 1'b1;
      else begin cycle(); n++; end
    end
  endtask

  initial begin
    int  n, cnt, t1, t2, ticks_seen, prev_time;
    bit  found, wrap_seen;

    rst_n = 1'b0; run = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_period = '0;
    bus.cfg_periodic = 1'b0; bus.cfg_start = 1'b0; bus.flag_clr = '0; bus.rd_ch = '0;
    cycle();
    cycle();

    // Prescaler from reset release, then run gating.
    rst_n = 1'b1; run = 1'b1;
    wait_tick(n, found);
    check("first_tick_found", 32'(found), 32'd1);
    check("first_tick_cycle", 32'(n), 32'(DIV));
    wait_tick(n, found);
    check("tick_period", 32'(n), 32'(DIV));
    run = 1'b0;
    cycle(); cycle(); cycle();
    run = 1'b1;
    wait_tick(n, found);
    check("run_gate_gap", 32'(n + 3), 32'(DIV + 3));

    // Periodic channel 0, period 3.
    cfg_write(0, 3, 1'b1, 1'b1);
    wait_expire(0, n, found);
    check("periodic_first_found", 32'(found), 32'd1);
    wait_expire(0, n, found);
    check("periodic_interval", 32'(n), 32'(3 * DIV));
    check("periodic_active", 32'(bus.active[0]), 32'd1);
    bus.flag_clr = 2'b01;
    cycle();
    bus.flag_clr = '0;
    check("flag_clr", 32'(bus.flag[0]), 32'd0);

    // One-shot channel 1, period 2.
    bus.rd_ch = 1'b1;
    cfg_write(1, 2, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20 * DIV + 8; i++) begin
      cycle();
      if (bus.expire[1]) cnt++;
    end
    check("oneshot_pulses", 32'(cnt), 32'd1);
    check("oneshot_active", 32'(bus.active[1]), 32'd0);
    check("oneshot_rd", 32'(bus.rd_count), 32'd0);

    // Re-arm collides with the expiring tick.
    wait_pre_expire0(found);
    check("rearm_window_found", 32'(found), 32'd1);
    bus.rd_ch = 1'b0;
    cfg_write(0, 5, 1'b1, 1'b1);
    check("rearm_no_expire", 32'(bus.expire[0]), 32'd0);
    cycle();
    check("rearm_count", 32'(bus.rd_count), 32'd5);

    // Flag clear collides with expiry set.
    wait_pre_expire0(found);
    check("clr_window_found", 32'(found), 32'd1);
    bus.flag_clr = 2'b01;
    cycle();
    bus.flag_clr = '0;
    check("clr_vs_expire_pulse", 32'(bus.expire[0]), 32'd1);
    check("clr_vs_expire_flag", 32'(bus.flag[0]), 32'd1);

    // Illegal zero-period arm, then stop with count held.
    cfg_write(0, 0, 1'b0, 1'b1);
    check("zero_period_ignored", 32'(bus.active[0]), 32'd1);
    cfg_write(0, 7, 1'b0, 1'b0);
    check("stop_active", 32'(bus.active[0]), 32'd0);
    for (int i = 0; i < 3 * DIV; i++) cycle();

    // out_time wrap and a period-255 channel.
    cfg_write(0, 5, 1'b1, 1'b1);
    bus.rd_ch = 1'b1;
    cfg_write(1, 255, 1'b1, 1'b1);
    ticks_seen = int'(tick);
    t1 = -1; t2 = -1; wrap_seen = 1'b0; prev_time = int'(out_time);
    for (int i = 0; i < 2300 && t2 < 0; i++) begin
      cycle();
      if (prev_time == 255 && out_time == 0) wrap_seen = 1'b1;
      prev_time = int'(out_time);
      if (bus.expire[1]) begin
        if (t1 < 0) t1 = ticks_seen; else t2 = ticks_seen;
      end
      ticks_seen += int'(tick);
    end
    check("time_wrap", 32'(wrap_seen), 32'd1);
    check("p255_first", 32'(t1), 32'd255);
    check("p255_second", 32'(t2), 32'd510);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      run              = ($urandom_range(0, 9) != 0);
      bus.cfg_we       = ($urandom_range(0, 5) == 0);
      bus.cfg_ch       = 1'($urandom_range(0, 1));
      bus.cfg_period   = WIDTH'($urandom_range(0, 6));
      bus.cfg_periodic = 1'($urandom_range(0, 1));
      bus.cfg_start    = ($urandom_range(0, 3) != 0);
      bus.flag_clr     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      bus.rd_ch        = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.cfg_we = 1'b0; bus.flag_clr = '0; run = 1'b1;

    // Reset mid-operation with both channels running.
    cfg_write(0, 2, 1'b1, 1'b1);
    cfg_write(1, 3, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("rst_out_time", 32'(out_time), 32'd0);
    check("rst_active", 32'(bus.active), 32'd0);
    check("rst_flag", 32'(bus.flag), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20 * DIV; i++) begin
      cycle();
      if (bus.expire != '0) cnt++;
    end
    check("post_rst_no_expire", 32'(cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
